// File: rtl/neuron_mac.sv
// Sequential fixed-point neuron: bias plus N_INPUTS streamed w*x products, rescaled and saturated.
// Optional ReLU on the result when NEURON_RELU_EN is defined.
module neuron_mac #(
    parameter int WIDTH     = 8,
    parameter int FRAC      = 6,
    parameter int N_INPUTS  = 4,
    parameter int ACC_WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_DONE} state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic        [CNT_W-1:0]       r_cnt;
    logic        [WIDTH-1:0]       r_out;
    logic                          r_ovf;

    logic signed [2*WIDTH-1:0]     w_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_bias;
    logic        [WIDTH:0]         w_sat;
    logic                          w_beat;
    logic                          w_last;

    // Rescale to the input format with truncation toward -inf; returns {clamped, value}.
    function automatic logic [WIDTH:0] f_sat(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] r;
        logic [WIDTH:0]              res;
        r = a >>> FRAC;
        if (r > SAT_MAX)
            res = {1'b1, SAT_MAX[WIDTH-1:0]};
        else if (r < SAT_MIN)
            res = {1'b1, SAT_MIN[WIDTH-1:0]};
        else
            res = {1'b0, r[WIDTH-1:0]};
`ifdef NEURON_RELU_EN
        if (res[WIDTH-1])
            res[WIDTH-1:0] = '0;
`endif
        return res;
    endfunction

    assign w_prod     = $signed(w) * $signed(x);
    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign w_bias     = ACC_WIDTH'($signed(b)) <<< FRAC;
    assign w_sat      = f_sat(r_acc);
    assign w_beat     = (r_state == S_ACCUM) && in_valid;
    assign w_last     = (r_cnt == CNT_W'(N_INPUTS - 1));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_ACCUM;
            S_ACCUM:  if (w_beat && w_last) w_next = S_FINISH;
            S_FINISH: w_next = S_DONE;
            S_DONE:   if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        in_ready  = (r_state == S_ACCUM);
        out_valid = (r_state == S_DONE);
    end

    // Full-precision accumulation; the result register only changes in FINISH so it is stable in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_out <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= w_bias;
                        r_cnt <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    r_out <= w_sat[WIDTH-1:0];
                    r_ovf <= w_sat[WIDTH];
                end
                default: ;
            endcase
        end
    end

    assign out = r_out;
    assign ovf = r_ovf;

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential, parametrised successor to the combinational fixed-point neuron. It accepts a bias, then streams N_INPUTS weight/input pairs over a valid/ready handshake and accumulates their products at full precision. It then rescales the sum to the input format with saturation, an overflow flag and optional ReLU, and presents the result on a valid/ready output port. It sits between the layer sequencer, which supplies weights, activations and bias, and the next layer's activation buffer.

## Interface
- WIDTH, 8: data width of w, x, b and out, signed two's complement.
- FRAC, 6: fractional bits of w, x, b and out. With the defaults the format is Q1.6, so 64 = 1.0.
- N_INPUTS, 4: number of w/x pairs per operation, ≥1.
- ACC_WIDTH, 20: accumulator width. Must satisfy ≥ 2*WIDTH + clog2(N_INPUTS+1) + 1.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin an operation. Sampled only in IDLE.
- b  input  WIDTH  bias, captured on the cycle start is accepted.
- busy  output  1  high in every state except IDLE.
- in_valid  input  1  w/x beat valid.
- in_ready  output  1  high only in ACCUM.
- w, x  input  WIDTH  weight and activation for the current beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out  output  WIDTH  saturated result.
- ovf  output  1  high if `out` was clamped. Valid with out_valid.

## Operation
- FSM states are IDLE, ACCUM, FINISH and DONE.
- **IDLE**
  - When start=1, load acc ← sign_ext(b) << FRAC and clear the beat counter.
  - Go to ACCUM.
- **ACCUM**
  - in_ready=1.
  - On each beat where in_valid & in_ready, add acc ← acc + sign_ext(w*x). The product is a 2*WIDTH-bit signed value with 2*FRAC fractional bits. Increment the counter.
  - When the counter reaches N_INPUTS-1 and a beat occurs, go to FINISH.
  - If in_valid is low, the state holds with no timeout.
- **FINISH** (one cycle)
  - Compute r = acc >>> FRAC. This is an arithmetic shift, which truncates toward −∞.
  - Clamp r to [−2^(WIDTH−1), 2^(WIDTH−1)−1], register the result into `out`, and set ovf if it was clamped.
  - Go to DONE.
- **DONE**
  - out_valid=1. `out` and `ovf` hold stable until out_valid & out_ready.
  - After that handshake, go to IDLE.
- The accumulator cannot overflow internally, given the ACC_WIDTH rule.
- start is ignored outside IDLE. In DONE, start does not pre-empt the pending result.
- A new start is accepted no earlier than the cycle after the output handshake.

## Timing
- **Reset values:** in_ready=0, out_valid=0, busy=0, out=0, ovf=0, acc=0, counter=0, state=IDLE.
- **Reset mid-operation:** on the next edge the block returns to IDLE. The partial sum and any pending result are discarded, and out_valid drops.
- **Latency:**
  - The start edge enters ACCUM and in_ready is high on the following cycle.
  - The first out_valid appears 2 cycles after the edge that accepts the Nth beat: one edge enters FINISH, one edge enters DONE.
  - With no stalls, one operation takes N_INPUTS+3 cycles from start to out_valid, plus 1 cycle for the output handshake.
- **Input handshake:** a beat transfers on the rising edge where in_valid & in_ready. w and x are sampled only on that edge.
- **Output handshake:** the result transfers on the edge where out_valid & out_ready. If out_ready is already high when DONE is entered, out_valid lasts exactly 1 cycle.
- **N_INPUTS=1:** ACCUM lasts exactly one accepted beat.

## Configuration
- **NEURON_RELU_EN**
  - Defined: in FINISH a negative clamped result is replaced by 0. ovf still reports negative clamping that occurred before the ReLU.
  - Undefined: the signed saturated result is output unchanged.

## Test plan
- Defaults, RELU off. b=−32 and four beats of w=32, x=32: each beat adds 1024 (0.25), so acc = −2048 + 4096 = 2048, and 2048 >>> 6 = 32. Required: out=32 (0x20), ovf=0, out_valid 7 cycles after start.
- b=0 and four beats of w=32, x=64, sum 2.0: out=127 (0x7F), ovf=1. Then b=0 and four beats of w=−128, x=127: out=−128 (0x80), ovf=1. With NEURON_RELU_EN defined, the second case gives out=0 with ovf=1.
- Truncation check. b=0 and four beats of w=1, x=1: out=0. Then b=0 and four beats of w=−1, x=1, so acc=−4: out=−1 (0xFF), ovf=0.
- in_valid toggled 1,0,0,1,0,1,1 with w=64, x=64 on valid cycles and b=0: exactly four beats are counted, giving out=127 (0x7F), ovf=1. in_ready stays high throughout ACCUM.
- out_ready held low for 5 cycles in DONE: out and ovf are stable and out_valid stays high. A start pulsed during DONE is ignored. Handshake on cycle 6, then IDLE and busy=0.
- rst asserted after 2 accepted beats: on the next edge all outputs take their reset values. A fresh operation with b=0 and four beats of w=64, x=16 gives out=64 (0x40), ovf=0, with no residue from the aborted sum.
